bcd_convert_arbiter: RTL and testbench
======================================

BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 The block SHALL have parameter NIBBLE_SIZE, default 2, which sets the number of hex nibbles per input value.
REQ-002 The block SHALL have derived localparam W, equal to 4*NIBBLE_SIZE, which is the input width in bits.
REQ-003 The block SHALL have derived localparam BCD_SIZE, equal to (N<5)?(N+1)*4 : (N<10)?(N+2)*4 : (N+3)*4 where N=NIBBLE_SIZE, which is the BCD output width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-005 clk  input  1  is the single clock; all state changes on the rising edge.
REQ-006 reset  input  1  is the synchronous, active-high reset.
REQ-007 reqA  input  1  is the conversion request from requester A (score display); it is level and held until doneA.
REQ-008 hexA  input  W  is the binary value for requester A; it is sampled on the accept edge only.
REQ-009 reqB  input  1  is the conversion request from requester B (cursor/status display).
REQ-010 hexB  input  W  is the binary value for requester B; it is sampled on the accept edge only.
REQ-011 busy  output  1  is high while a conversion is in progress (SHIFT or DONE).
REQ-012 doneA  output  1  is a one-cycle pulse when the result for A is valid.
REQ-013 doneB  output  1  is a one-cycle pulse when the result for B is valid.
REQ-014 bcdValue  output  BCD_SIZE  is the last completed result, held until the next completion.

Function
REQ-015 The block SHALL share one sequential shift-add-3 (double-dabble) converter between requesters A and B.
REQ-016 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-017 IDLE SHALL accept the granted request: latch the winner's hex into the shift register, clear the BCD accumulator, set count=W, record the grant owner, and go to SHIFT.
REQ-018 Each SHIFT edge SHALL add 3 to every BCD digit that is >=5, shift {bcd,bin} left by one bit, and decrement count.
REQ-019 The final SHIFT edge (count reaches 0) SHALL load bcdValue and go to DONE.
REQ-020 DONE SHALL last exactly one cycle, assert the done output of the grant owner, and return to IDLE.
REQ-021 Latency SHALL be: done high in the cycle following W+1 rising edges after the accept edge (NIBBLE_SIZE=2: 9 edges).
REQ-022 Requests SHALL be sampled only in IDLE; reqA and reqB are ignored in SHIFT and DONE.
REQ-023 A requester SHALL deassert its req during its done cycle; a req still high in IDLE is treated as a new request.
REQ-024 A req dropped mid-conversion SHALL NOT abort the conversion: it completes and done still pulses; there is no abort path.
REQ-025 A change on hexA or hexB after the accept edge SHALL NOT affect the running conversion.
REQ-026 doneA and doneB SHALL never be high in the same cycle.
REQ-027 busy SHALL be low in IDLE only.
REQ-028 The maximum input value 2^W-1 SHALL convert without overflow within BCD_SIZE bits.

Reset
REQ-029 When reset is high on a clock edge, the FSM SHALL go to IDLE with busy=0, doneA=0, doneB=0, bcdValue=0, and count, shift register and grant owner cleared.
REQ-030 Reset mid-conversion SHALL discard the conversion with no done pulse.
REQ-031 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-032 The macro BCDARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-033 With BCDARB_ROUND_ROBIN_EN defined, when both requests are high in IDLE, the requester not served last SHALL win; the last-served pointer resets to B, so A wins the first tie.
REQ-034 With BCDARB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority: A always wins a tie, and the pointer logic is not built.

Structure
REQ-035 A shared package bcd_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), a BCD_SIZE function of NIBBLE_SIZE, and the add-3 threshold constant (5).
REQ-036 One sub-module SHALL be used: bcd_dabble_step, the combinational per-cycle correct-and-shift of {bcd,bin}, instantiated once.
REQ-037 The FSM, the arbiter and the counter SHALL live in the top level.

Verification
REQ-038 Reset: assert reset for 2 cycles -> busy=0, doneA=0, doneB=0, bcdValue=12'h000.
REQ-039 Single request: reqA=1, hexA=8'hFF -> doneA pulses 9 edges after accept, bcdValue=12'h255, doneB stays 0.
REQ-040 Tie: reqA=1, hexA=8'h0A and reqB=1, hexB=8'h63 together -> A served first (bcdValue=12'h010, doneA), then B (12'h099, doneB); with BCDARB_ROUND_ROBIN_EN, a second tie serves B first.
REQ-041 Reset mid-operation: reset on the 4th SHIFT edge -> IDLE, no done pulse, bcdValue=0.
REQ-042 Dropped request: reqB dropped after the 2nd SHIFT edge, hexB=8'h80 -> doneB still pulses, bcdValue=12'h128.
REQ-043 Exhaustive sweep: hexA from 0 to 255, back-to-back handshakes -> every result equals {i/100, (i/10)%10, i%10}.

Source files
------------

// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared definitions for the BCD conversion arbiter: FSM state type,
// BCD output width helper and the double-dabble add-3 threshold.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digits with this value or more get +3 before each shift.
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // BCD width needed to hold 2^(4*n)-1 without overflow.
  function automatic int unsigned bcd_size(input int unsigned n);
    if (n < 5) begin
      return (n + 1) * 4;
    end else if (n < 10) begin
      return (n + 2) * 4;
    end else begin
      return (n + 3) * 4;
    end
  endfunction

endpackage

// File: rtl/bcd_convert_arbiter_dabble_step.sv
// One double-dabble iteration: correct every BCD digit >= 5 by adding 3,
// then shift the concatenation {bcd, bin} left by one bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter  int NIBBLE_SIZE = 2,
  localparam int W           = 4 * NIBBLE_SIZE,
  localparam int BCD_SIZE    = int'(bcd_size(NIBBLE_SIZE))
) (
  input  logic [BCD_SIZE-1:0] i_bcd,
  input  logic [W-1:0]        i_bin,
  output logic [BCD_SIZE-1:0] o_bcd,
  output logic [W-1:0]        o_bin
);

  logic [BCD_SIZE-1:0] w_corr;

  // Per-digit add-3 correction ahead of the shift.
  always_comb begin
    w_corr = i_bcd;
    for (int unsigned d = 0; d < BCD_SIZE / 4; d++) begin
      if (i_bcd[4*d +: 4] >= ADD3_THRESHOLD) begin
        w_corr[4*d +: 4] = i_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign o_bcd = {w_corr[BCD_SIZE-2:0], i_bin[W-1]};
  assign o_bin = {i_bin[W-2:0], 1'b0};

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Two-requester arbiter sharing one sequential binary-to-BCD converter.
// Requester A: score display, requester B: cursor/status display.
// Optional macro BCDARB_ROUND_ROBIN_EN: round-robin tie breaking
// (otherwise A always wins a tie).
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter  int NIBBLE_SIZE = 2,
  localparam int W           = 4 * NIBBLE_SIZE,
  localparam int BCD_SIZE    = int'(bcd_size(NIBBLE_SIZE))
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqA,
  input  logic [W-1:0]        hexA,
  input  logic                reqB,
  input  logic [W-1:0]        hexB,
  output logic                busy,
  output logic                doneA,
  output logic                doneB,
  output logic [BCD_SIZE-1:0] bcdValue
);

  localparam int COUNT_W = $clog2(W + 1);

  state_t              r_state;
  logic [W-1:0]        r_bin;
  logic [BCD_SIZE-1:0] r_bcd;
  logic [COUNT_W-1:0]  r_count;
  logic                r_owner_b;
  logic                r_busy;
  logic                r_doneA;
  logic                r_doneB;
  logic [BCD_SIZE-1:0] r_bcd_value;

  logic                w_accept;
  logic                w_grant_b;
  logic [BCD_SIZE-1:0] w_bcd_next;
  logic [W-1:0]        w_bin_next;

  assign w_accept = reqA | reqB;

`ifdef BCDARB_ROUND_ROBIN_EN
  logic r_last_b;

  // On a tie the requester not served last wins.
  always_comb begin
    w_grant_b = reqB & (~reqA | ~r_last_b);
  end

  // Last-served pointer; starts at B so A takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (r_state == IDLE && w_accept) begin
      r_last_b <= w_grant_b;
    end
  end
`else
  // Fixed priority: A always wins a tie.
  always_comb begin
    w_grant_b = reqB & ~reqA;
  end
`endif

  bcd_dabble_step #(
    .NIBBLE_SIZE (NIBBLE_SIZE)
  ) u_step (
    .i_bcd (r_bcd),
    .i_bin (r_bin),
    .o_bcd (w_bcd_next),
    .o_bin (w_bin_next)
  );

  // Conversion FSM: accept in IDLE, W shift edges, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_count     <= '0;
      r_owner_b   <= 1'b0;
      r_busy      <= 1'b0;
      r_doneA     <= 1'b0;
      r_doneB     <= 1'b0;
      r_bcd_value <= '0;
    end else begin
      r_doneA <= 1'b0;
      r_doneB <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bin     <= w_grant_b ? hexB : hexA;
            r_bcd     <= '0;
            r_count   <= COUNT_W'(W);
            r_owner_b <= w_grant_b;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd   <= w_bcd_next;
          r_bin   <= w_bin_next;
          r_count <= r_count - 1'b1;
          if (r_count == COUNT_W'(1)) begin
            r_bcd_value <= w_bcd_next;
            r_doneA     <= ~r_owner_b;
            r_doneB     <= r_owner_b;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign doneA    = r_doneA;
  assign doneB    = r_doneB;
  assign bcdValue = r_bcd_value;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench for bcd_convert_arbiter (NIBBLE_SIZE=2, 12-bit BCD).
// Honours BCDARB_ROUND_ROBIN_EN in its arbitration model.
module tb_bcd_convert_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA, reqB;
  logic [7:0]  hexA, hexB;
  logic        busy, doneA, doneB;
  logic [11:0] bcdValue;

  int n_total = 0;
  int n_bad   = 0;
  bit m_last_b = 1'b1;

  bcd_convert_arbiter #(
    .NIBBLE_SIZE (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reqA     (reqA),
    .hexA     (hexA),
    .reqB     (reqB),
    .hexB     (hexB),
    .busy     (busy),
    .doneA    (doneA),
    .doneB    (doneB),
    .bcdValue (bcdValue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal digits by plain arithmetic.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Waits (bounded) for a done pulse, sampling on negedges.
  task automatic wait_done(input int drop_at, input int scr_at, input int busy_from,
                           output logic gA, output logic gB, output int edges);
    gA = 1'b0; gB = 1'b0; edges = 0;
    while (!(gA || gB) && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == scr_at) begin
        hexA = 8'($urandom);
        hexB = 8'($urandom);
      end
      if (edges == drop_at) begin
        reqA = 1'b0;
        reqB = 1'b0;
      end
      if (doneA || doneB) begin
        gA = doneA;
        gB = doneB;
        check("done_excl", 32'(doneA & doneB), 32'd0);
        if (doneA) reqA = 1'b0;
        if (doneB) reqB = 1'b0;
      end else if (edges >= busy_from) begin
        check("busy_run", 32'(busy), 32'd1);
      end
    end
    check("done_seen", 32'(gA | gB), 32'd1);
  endtask

  // One handshake (or two on a tie); called and returning on a negedge in IDLE.
  task automatic run_txn(input bit ra, input bit rb, input logic [7:0] ha,
                         input logic [7:0] hb, input int drop_at, input bit scr);
    bit win_b;
    logic gA, gB;
    int edges;
    logic [11:0] exp1, exp2;
    if (ra && rb) begin
`ifdef BCDARB_ROUND_ROBIN_EN
      win_b = !m_last_b;
`else
      win_b = 1'b0;
`endif
    end else begin
      win_b = rb;
    end
    exp1 = to_bcd(win_b ? int'(hb) : int'(ha));
    reqA = ra; reqB = rb; hexA = ha; hexB = hb;
    wait_done(drop_at, scr ? 1 : 0, 1, gA, gB, edges);
    check("latency", 32'(edges), 32'd9);
    check("doneA", 32'(gA), 32'(!win_b));
    check("doneB", 32'(gB), 32'(win_b));
    check("bcd", 32'(bcdValue), 32'(exp1));
    m_last_b = win_b;
    if (ra && rb) begin
      exp2 = to_bcd(win_b ? int'(hexA) : int'(hexB));
      wait_done(0, scr ? 2 : 0, 2, gA, gB, edges);
      check("latency2", 32'(edges), 32'd10);
      check("doneA2", 32'(gA), 32'(win_b));
      check("doneB2", 32'(gB), 32'(!win_b));
      check("bcd2", 32'(bcdValue), 32'(exp2));
      m_last_b = !win_b;
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'({doneA, doneB}), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqA = 1'b0; reqB = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_last_b = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_doneA", 32'(doneA), 32'd0);
    check("rst_doneB", 32'(doneB), 32'd0);
    check("rst_bcd", 32'(bcdValue), 32'h000);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    reset = 1'b1; reqA = 1'b0; reqB = 1'b0; hexA = '0; hexB = '0;
    @(negedge clk);
    do_reset();

    // Single request, maximum value.
    run_txn(1'b1, 1'b0, 8'hFF, 8'h00, 0, 1'b0);

    // Tie, then single A followed by another tie.
    run_txn(1'b1, 1'b1, 8'h0A, 8'h63, 0, 1'b0);
    run_txn(1'b1, 1'b0, 8'h2A, 8'h00, 0, 1'b0);
    run_txn(1'b1, 1'b1, 8'h0A, 8'h63, 0, 1'b0);

    // Reset on the 4th SHIFT edge: conversion discarded, no done.
    reqA = 1'b1; hexA = 8'hC8;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; reqA = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_last_b = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd", 32'(bcdValue), 32'h000);
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (doneA || doneB) dones++;
    end
    check("midrst_nodone", 32'(dones), 32'd0);

    // Request dropped after the 2nd SHIFT edge still completes.
    run_txn(1'b0, 1'b1, 8'h00, 8'h80, 3, 1'b0);

    // Exhaustive back-to-back sweep on A.
    for (int i = 0; i < 256; i++) begin
      run_txn(1'b1, 1'b0, 8'(i), 8'h00, 0, 1'b0);
    end

    // Random mix with hex inputs changing during conversion.
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      run_txn(sel[0], sel[1], 8'($urandom), 8'($urandom), 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
